// File: rtl/mem_pkg.sv
// Shared memory-array definitions used by the address decoders and the array itself.
package mem_pkg;

    // Widest index a single decoder instance is expected to handle.
    localparam int MAX_DECODE_WIDTH = 8;

    // Number of select lines produced by a decoder of the given index width.
    function automatic int num_lines(input int w);
        return 1 << w;
    endfunction

endpackage

// File: rtl/predecode2.sv
// Predecoder for one address group: turns a 1- or 2-bit slice into one-hot lines.
module predecode2 #(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0]      sel_i,
    output logic [(1<<WIDTH)-1:0] line_o
);

    // Raise exactly the line selected by the group value.
    always_comb begin
        line_o        = '0;
        line_o[sel_i] = 1'b1;
    end

endmodule

// File: rtl/x_decode.sv
// One-hot row/column decoder: predecodes the index in 2-bit groups, ANDs the
// group lines into the final select plane, and optionally registers the result.
module x_decode
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH   = 4,
    parameter int REGISTER_OUT = 1
) (
    input  logic                            Clock,
    input  logic                            Reset,
    input  logic                            En,
    input  logic [ADDR_WIDTH-1:0]           addr,
    output logic [num_lines(ADDR_WIDTH)-1:0] loc,
    output logic                            loc_valid
);

    localparam int NUM_LINES  = num_lines(ADDR_WIDTH);
    localparam int NUM_GROUPS = (ADDR_WIDTH + 1) / 2;

    // Predecoded lines, one 4-line bundle per group; an odd trailing group only
    // drives its two low lines, the upper two stay at zero.
    logic [NUM_GROUPS-1:0][3:0] preLines;

    logic [NUM_LINES-1:0] loc_d;
    logic                 valid_d;

    genvar g;
    generate
        for (g = 0; g < NUM_GROUPS; g++) begin : gen_group
            if ((2 * g + 2) <= ADDR_WIDTH) begin : gen_pair
                logic [3:0] lines;
                predecode2 #(.WIDTH(2)) u_pre (
                    .sel_i  (addr[2*g+1:2*g]),
                    .line_o (lines)
                );
                assign preLines[g] = lines;
            end else begin : gen_single
                logic [1:0] lines;
                predecode2 #(.WIDTH(1)) u_pre (
                    .sel_i  (addr[2*g]),
                    .line_o (lines)
                );
                assign preLines[g] = {2'b00, lines};
            end
        end
    endgenerate

    // AND plane: each select is the product of its matching line from every group, gated by En.
    always_comb begin
        loc_d   = '0;
        valid_d = En;
        for (int k = 0; k < NUM_LINES; k++) begin
            logic term;
            term = En;
            for (int gi = 0; gi < NUM_GROUPS; gi++) begin
                term = term & preLines[gi][(k >> (2 * gi)) & 3];
            end
            loc_d[k] = term;
        end
    end

    generate
        if (REGISTER_OUT != 0) begin : gen_reg
            logic [NUM_LINES-1:0] loc_q;
            logic                 valid_q;

            // Output flops reload every edge; disabled decode loads zero, reset clears at once.
            always_ff @(posedge Clock or posedge Reset) begin
                if (Reset) begin
                    loc_q   <= '0;
                    valid_q <= 1'b0;
                end else begin
                    loc_q   <= loc_d;
                    valid_q <= valid_d;
                end
            end

            assign loc       = loc_q;
            assign loc_valid = valid_q;
        end else begin : gen_comb
            // The clock has no role when the decode is purely combinational.
            logic unusedClock;
            assign unusedClock = Clock;

            // Pass the decode straight through, still forced to zero while reset is held.
            always_comb begin
                loc       = Reset ? '0 : loc_d;
                loc_valid = Reset ? 1'b0 : valid_d;
            end
        end
    endgenerate

endmodule

// File: tb/tb_x_decode.sv
// Directed bench for x_decode: a registered 4-bit instance and a combinational 3-bit instance.
module tb_x_decode;

    logic        clock;
    logic        reset4;
    logic        en4;
    logic [3:0]  addr4;
    logic [15:0] loc4;
    logic        valid4;

    logic        reset3;
    logic        en3;
    logic [2:0]  addr3;
    logic [7:0]  loc3;
    logic        valid3;

    int compared;
    int mismatched;

    typedef struct {
        string       name;
        logic        en;
        logic [3:0]  addr;
        logic [15:0] expLoc;
        logic        expValid;
    } vec_t;

    vec_t vecs[8];

    x_decode #(.ADDR_WIDTH(4), .REGISTER_OUT(1)) dutReg (
        .Clock     (clock),
        .Reset     (reset4),
        .En        (en4),
        .addr      (addr4),
        .loc       (loc4),
        .loc_valid (valid4)
    );

    x_decode #(.ADDR_WIDTH(3), .REGISTER_OUT(0)) dutComb (
        .Clock     (clock),
        .Reset     (reset3),
        .En        (en3),
        .addr      (addr3),
        .loc       (loc3),
        .loc_valid (valid3)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic applyStimulus(input logic en, input logic [3:0] addr);
        @(negedge clock);
        en4   = en;
        addr4 = addr;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actLoc,
                               input logic [15:0] expLoc, input logic actValid,
                               input logic expValid);
        compared++;
        if (actLoc !== expLoc || actValid !== expValid) begin
            mismatched++;
            $display("[TB] FAIL %s: loc=%h valid=%b, required loc=%h valid=%b",
                     name, actLoc, actValid, expLoc, expValid);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset4 = 1'b1;
        en4    = 1'b0;
        addr4  = '0;
        reset3 = 1'b0;
        en3    = 1'b0;
        addr3  = '0;

        vecs[0] = '{"corner_addr0",  1'b1, 4'd0,  16'h0001, 1'b1};
        vecs[1] = '{"corner_addr15", 1'b1, 4'd15, 16'h8000, 1'b1};
        vecs[2] = '{"corner_addr5",  1'b1, 4'd5,  16'h0020, 1'b1};
        vecs[3] = '{"gate_off_9",    1'b0, 4'd9,  16'h0000, 1'b0};
        vecs[4] = '{"gate_on_9",     1'b1, 4'd9,  16'h0200, 1'b1};
        vecs[5] = '{"addr3",         1'b1, 4'd3,  16'h0008, 1'b1};
        vecs[6] = '{"en_fall",       1'b0, 4'd3,  16'h0000, 1'b0};
        vecs[7] = '{"addr12",        1'b1, 4'd12, 16'h1000, 1'b1};

        #1;
        checkOutput("reset_state", loc4, 16'h0000, valid4, 1'b0);
        @(posedge clock);
        #1;
        checkOutput("reset_held_edge", loc4, 16'h0000, valid4, 1'b0);
        @(negedge clock);
        reset4 = 1'b0;

        // Table vectors: each shows up one edge after being driven.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].en, vecs[i].addr);
            @(posedge clock);
            #1;
            checkOutput(vecs[i].name, loc4, vecs[i].expLoc, valid4, vecs[i].expValid);
        end

        // Asynchronous reset mid-cycle while loc holds 16'h0020.
        applyStimulus(1'b1, 4'd5);
        @(posedge clock);
        #1;
        checkOutput("pre_reset_load", loc4, 16'h0020, valid4, 1'b1);
        #1;
        reset4 = 1'b1;
        #1;
        checkOutput("async_reset_clear", loc4, 16'h0000, valid4, 1'b0);
        @(posedge clock);
        #1;
        checkOutput("reset_discards_pending", loc4, 16'h0000, valid4, 1'b0);
        @(negedge clock);
        reset4 = 1'b0;
        addr4  = 4'd10;
        @(posedge clock);
        #1;
        checkOutput("first_after_reset", loc4, 16'h0400, valid4, 1'b1);

        // Back-to-back sweep of every index with no idle cycle between them.
        for (int n = 0; n < 16; n++) begin
            applyStimulus(1'b1, n[3:0]);
            @(posedge clock);
            #1;
            checkOutput($sformatf("sweep_%0d", n), loc4, 16'(1 << n), valid4, 1'b1);
            compared++;
            if ($countones(loc4) != 1) begin
                mismatched++;
                $display("[TB] FAIL sweep_onehot_%0d: popcount=%0d, required 1",
                         n, $countones(loc4));
            end
        end

        // Combinational, odd-width instance: output follows inputs with no edge.
        en3   = 1'b1;
        addr3 = 3'd6;
        #1;
        checkOutput("comb_addr6", {8'h00, loc3}, 16'h0040, valid3, 1'b1);
        reset3 = 1'b1;
        #1;
        checkOutput("comb_reset", {8'h00, loc3}, 16'h0000, valid3, 1'b0);
        reset3 = 1'b0;
        en3    = 1'b0;
        #1;
        checkOutput("comb_en_off", {8'h00, loc3}, 16'h0000, valid3, 1'b0);
        en3   = 1'b1;
        addr3 = 3'd0;
        #1;
        checkOutput("comb_addr0", {8'h00, loc3}, 16'h0001, valid3, 1'b1);
        addr3 = 3'd7;
        #1;
        checkOutput("comb_addr7", {8'h00, loc3}, 16'h0080, valid3, 1'b1);
        addr3 = 3'd5;
        #1;
        checkOutput("comb_addr5", {8'h00, loc3}, 16'h0020, valid3, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
